// File: rtl/pong_game_fsm_if.sv
// rtl/pong_game_fsm_if.sv - game-control signal bundle between the pong datapath and its FSM
interface pong_game_fsm_if #(
   parameter int SCORE_W   = 4,
   parameter int MAX_SPEED = 3
);
   localparam int SPD_W = $clog2(MAX_SPEED + 1);

   logic               frame_tick;
   logic               start;
   logic               player_collision;
   logic               ai_collision;
   logic               player_scored;
   logic               ai_scored;
   logic               ball_too_high;
   logic               ball_too_low;
   logic               x_dir;
   logic               y_dir;
   logic               en_ball;
   logic               ball_reset;
   logic [SCORE_W-1:0] player_score;
   logic [SCORE_W-1:0] ai_score;
   logic [SPD_W-1:0]   speed;
   logic               game_over;
   logic               winner;

   modport master (
      output frame_tick, start, player_collision, ai_collision,
             player_scored, ai_scored, ball_too_high, ball_too_low,
      input  x_dir, y_dir, en_ball, ball_reset, player_score, ai_score,
             speed, game_over, winner
   );

   modport slave (
      input  frame_tick, start, player_collision, ai_collision,
             player_scored, ai_scored, ball_too_high, ball_too_low,
      output x_dir, y_dir, en_ball, ball_reset, player_score, ai_score,
             speed, game_over, winner
   );
endinterface

// File: rtl/pong_game_fsm.sv
// rtl/pong_game_fsm.sv - pong game sequencer: serve timing, ball direction, scoring, speed levels
module pong_game_fsm #(
   parameter int SCORE_W        = 4,
   parameter int WIN_SCORE      = 7,
   parameter int SERVE_DELAY    = 60,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MAX_SPEED      = 3
) (
   input  logic            clk,
   input  logic            reset,
   pong_game_fsm_if.slave  bus
);
   localparam int SPD_W = $clog2(MAX_SPEED + 1);
   localparam int SRV_W = $clog2(SERVE_DELAY + 1);
   localparam int RAL_W = $clog2(HITS_PER_LEVEL + 1);

   localparam logic [SRV_W-1:0]   SERVE_LAST = SRV_W'(SERVE_DELAY - 1);
   localparam logic [RAL_W-1:0]   HITS_LAST  = RAL_W'(HITS_PER_LEVEL - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [SPD_W-1:0]   SPD_MAX    = SPD_W'(MAX_SPEED);
   localparam logic [SPD_W-1:0]   SPD_ONE    = SPD_W'(1);

   typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;

   state_t             state_q, state_d;
   logic               x_q, x_d, y_q, y_d, br_q, br_d, go_q, go_d, win_q, win_d;
   logic [SCORE_W-1:0] ps_q, ps_d, as_q, as_d;
   logic [SPD_W-1:0]   spd_q, spd_d;
   logic [RAL_W-1:0]   rally_q, rally_d;
   logic [SRV_W-1:0]   serve_q, serve_d;
   logic               hit;

   // A paddle only counts when the ball is travelling toward it, so a
   // collision held for several cycles bounces exactly once.
   assign hit = (bus.player_collision && !x_q) || (bus.ai_collision && x_q);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ps_d    = ps_q;
      as_d    = as_q;
      spd_d   = spd_q;
      rally_d = rally_q;
      serve_d = serve_q;
      win_d   = win_q;
      unique case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d = SERVE;
               ps_d    = '0;
               as_d    = '0;
               win_d   = 1'b0;
            end
         end
         SERVE: begin
            if (bus.frame_tick) begin
               if (serve_q == SERVE_LAST) begin
                  state_d = PLAY;
                  serve_d = '0;
               end else begin
                  serve_d = serve_q + 1'b1;
               end
            end
         end
         PLAY: begin
            if (bus.player_scored || bus.ai_scored) begin
               state_d = SCORED;
               if (bus.player_scored && !bus.ai_scored) begin
                  ps_d = ps_q + 1'b1;
                  x_d  = 1'b0;
               end else if (bus.ai_scored && !bus.player_scored) begin
                  as_d = as_q + 1'b1;
                  x_d  = 1'b1;
               end
            end else if (hit) begin
               x_d = !x_q;
               if (rally_q == HITS_LAST) begin
                  rally_d = '0;
                  if (spd_q != SPD_MAX) spd_d = spd_q + 1'b1;
               end else begin
                  rally_d = rally_q + 1'b1;
               end
            end else if (bus.ball_too_high != bus.ball_too_low) begin
               y_d = bus.ball_too_high;
            end
         end
         SCORED: state_d = (ps_q == WIN || as_q == WIN) ? OVER : SERVE;
         default: state_d = IDLE;
      endcase

      if (state_d == SERVE && state_q != SERVE) begin
         spd_d   = SPD_ONE;
         rally_d = '0;
         serve_d = '0;
      end
      if (state_d == OVER && state_q != OVER) win_d = (ps_d == WIN);
      go_d = (state_d == OVER);
      br_d = (state_d != PLAY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= 1'b1;
         y_q     <= 1'b0;
         br_q    <= 1'b1;
         go_q    <= 1'b0;
         win_q   <= 1'b0;
         ps_q    <= '0;
         as_q    <= '0;
         spd_q   <= SPD_ONE;
         rally_q <= '0;
         serve_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         br_q    <= br_d;
         go_q    <= go_d;
         win_q   <= win_d;
         ps_q    <= ps_d;
         as_q    <= as_d;
         spd_q   <= spd_d;
         rally_q <= rally_d;
         serve_q <= serve_d;
      end
   end

   assign bus.x_dir        = x_q;
   assign bus.y_dir        = y_q;
   assign bus.ball_reset   = br_q;
   assign bus.game_over    = go_q;
   assign bus.winner       = win_q;
   assign bus.player_score = ps_q;
   assign bus.ai_score     = as_q;
   assign bus.speed        = spd_q;
   assign bus.en_ball      = bus.frame_tick && (state_q == PLAY);
endmodule

// File: doc/pong_game_fsm.md
PONG_GAME_FSM -- requirements
Module: pong_game_fsm

Interface
REQ-001 SHALL have parameter SCORE_W, 4, width of each score counter.
REQ-002 SHALL have parameter WIN_SCORE, 7, points that end a game; legal range 1..2^SCORE_W-1.
REQ-003 SHALL have parameter SERVE_DELAY, 60, frame ticks spent in SERVE before play starts; legal range >=1.
REQ-004 SHALL have parameter HITS_PER_LEVEL, 4, paddle hits per speed step; legal range >=1.
REQ-005 SHALL have parameter MAX_SPEED, 3, speed saturation value; SPD_W = clog2(MAX_SPEED+1).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port start  input  1  level; starts a new game from IDLE or OVER.
REQ-010 SHALL have ports player_collision, ai_collision  input  1 each  ball touching the player or AI paddle.
REQ-011 SHALL have ports player_scored, ai_scored  input  1 each  ball passed the AI edge or the player edge.
REQ-012 SHALL have ports ball_too_high, ball_too_low  input  1 each  ball at the top wall or bottom wall.
REQ-013 SHALL have port x_dir  output  1  1 = toward AI, 0 = toward player.
REQ-014 SHALL have port y_dir  output  1  1 = down, 0 = up.
REQ-015 SHALL have port en_ball  output  1  ball-move strobe.
REQ-016 SHALL have port ball_reset  output  1  hold the ball at centre.
REQ-017 SHALL have ports player_score, ai_score  output  SCORE_W each  registered scores.
REQ-018 SHALL have port speed  output  SPD_W  pixels per frame.
REQ-019 SHALL have ports game_over, winner  output  1 each  end-of-game flag; winner 1 = player won.

Function
REQ-020 SHALL implement states IDLE, SERVE, PLAY, SCORED and OVER, with all outputs registered except en_ball.
REQ-021 IDLE: ball_reset=1; start=1 -> SERVE, clearing both scores and setting winner=0.
REQ-022 SERVE: ball_reset=1, speed=1, rally count=0; serve counter increments on each frame_tick; the tick that makes the count reach SERVE_DELAY -> PLAY, counter cleared.
REQ-023 PLAY: en_ball = frame_tick (combinational AND with state==PLAY); en_ball SHALL be 0 in all other states.
REQ-024 PLAY event priority within a cycle SHALL be: scored > paddle collision > wall.
REQ-025 player_scored only: player_score+1, x_dir<=0 (next serve goes toward the player), -> SCORED.
REQ-026 ai_scored only: ai_score+1, x_dir<=1, -> SCORED.
REQ-027 player_scored and ai_scored together: no score change, x_dir unchanged, -> SCORED.
REQ-028 player_collision SHALL be honoured only when x_dir=0 (x_dir<=1); ai_collision SHALL be honoured only when x_dir=1 (x_dir<=0); a collision against the current direction SHALL be ignored, which prevents a double bounce.
REQ-029 Each honoured collision SHALL increment the rally count; when the count reaches HITS_PER_LEVEL it SHALL wrap to 0 and speed SHALL increment, saturating at MAX_SPEED.
REQ-030 ball_too_high alone -> y_dir<=1; ball_too_low alone -> y_dir<=0; both together -> y_dir unchanged.
REQ-031 SCORED SHALL last exactly one cycle: if either score == WIN_SCORE -> OVER, else -> SERVE.
REQ-032 OVER: game_over=1, ball_reset=1, winner = (player_score == WIN_SCORE); scores held; start=1 -> SERVE with scores cleared and game_over<=0.
REQ-033 start SHALL be ignored in SERVE, PLAY and SCORED.
REQ-034 Scores SHALL change only in PLAY and SHALL never exceed WIN_SCORE.

Reset
REQ-035 reset=0 SHALL immediately force state=IDLE, scores=0, x_dir=1, y_dir=0, speed=1, rally and serve counters=0, game_over=0, winner=0, ball_reset=1, and en_ball=0, regardless of the current state, including mid-PLAY.
REQ-036 After reset is released, the first transition SHALL occur no earlier than the next rising clk edge.

Verification (SERVE_DELAY=3, WIN_SCORE=2, HITS_PER_LEVEL=2, MAX_SPEED=3)
REQ-037 Pulse start, then 3 frame_ticks -> PLAY entered on the 3rd tick; ball_reset 1->0; en_ball mirrors frame_tick only in PLAY.
REQ-038 In PLAY with x_dir=1, assert ai_collision 2 cycles, then player_collision -> x_dir 1->0 after the first cycle, the second cycle ignored, then 0->1; rally count=2 wraps, speed=2; 4 more honoured hits -> speed=3 and stays 3.
REQ-039 ball_too_high -> y_dir=1; both wall inputs together -> y_dir held; ball_too_low -> y_dir=0.
REQ-040 player_scored twice (each followed by a serve) -> player_score=1 then 2; SCORED -> OVER; game_over=1, winner=1; start -> scores 0, game_over=0, SERVE.
REQ-041 player_scored, ai_scored and ai_collision in the same cycle -> scores unchanged, -> SCORED -> SERVE; speed=1.
REQ-042 Drive reset=0 mid-PLAY with speed=2 and ai_score=1 -> all outputs at reset values within the same cycle, before the next clk edge.
